// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register: owns the PC, keeps one request
// outstanding to variable-latency instruction memory, and absorbs stalls and redirects.
module if_fetch_unit #(
    parameter int               INS_ADDRESS = 9,
    parameter int               INS_W       = 32,
    parameter int               PC_STEP     = 4,
    parameter logic [INS_W-1:0] NOP_INST    = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_en,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    output logic                   imem_req,
    output logic [INS_ADDRESS-1:0] imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INS_W-1:0]       imem_rdata,
    output logic [INS_W-1:0]       INSTout,
    output logic [INS_ADDRESS-1:0] PCout,
    output logic                   valid_out
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

    localparam logic [INS_ADDRESS-1:0] STEP = INS_ADDRESS'(PC_STEP);

    state_t                 state_q, state_d;
    logic [INS_ADDRESS-1:0] pc_q, pc_d, pc_inc;
    logic [INS_ADDRESS-1:0] hold_pc_q, hold_pc_d;
    logic [INS_W-1:0]       hold_inst_q, hold_inst_d;
    logic [INS_ADDRESS-1:0] out_pc_q, out_pc_d;
    logic [INS_W-1:0]       out_inst_q, out_inst_d;
    logic                   out_valid_q, out_valid_d;
    logic                   accept, consume, req_int;

    assign pc_inc  = pc_q + STEP;
    assign accept  = !out_valid_q || !stall;
    assign consume = out_valid_q && !stall;

    // Requests are suppressed outright while reset is held, regardless of state.
    assign imem_req  = rst && req_int;
    assign INSTout   = out_inst_q;
    assign PCout     = out_pc_q;
    assign valid_out = out_valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        req_int     = 1'b0;
        imem_addr   = pc_q;

        // A consumed instruction empties the output unless something reloads it below.
        if (consume) begin
            out_valid_d = 1'b0;
            out_inst_d  = NOP_INST;
        end

        if (redirect_en) begin
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            out_inst_d  = NOP_INST;
            hold_pc_d   = '0;
            hold_inst_d = NOP_INST;
            case (state_q)
                IDLE:    state_d = IDLE;
                WAIT:    state_d = imem_rvalid ? REQ : DRAIN;
                DRAIN:   state_d = DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    req_int = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_inc;
                        if (accept) begin
                            out_inst_d  = imem_rdata;
                            out_pc_d    = pc_q;
                            out_valid_d = 1'b1;
                            req_int     = 1'b1;
                            imem_addr   = pc_inc;
                        end else begin
                            hold_inst_d = imem_rdata;
                            hold_pc_d   = pc_q;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        out_inst_d  = hold_inst_q;
                        out_pc_d    = hold_pc_q;
                        out_valid_d = 1'b1;
                        state_d     = REQ;
                    end
                end
                DRAIN: begin
                    // The stale response is swallowed here; fetch restarts at the new PC.
                    if (imem_rvalid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            hold_pc_q   <= '0;
            hold_inst_q <= NOP_INST;
            out_pc_q    <= '0;
            out_inst_q  <= NOP_INST;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues single-outstanding read requests to instruction memory, which has variable latency.
- Presents {instruction, PC, valid} to the IF/ID register.
- Handles hazard-unit stalls and branch/jump redirects, including discarding stale in-flight responses.

Parameters:
- INS_ADDRESS, 9, PC / instruction-address width in bits
- INS_W, 32, instruction width
- PC_STEP, 4, PC increment per sequential fetch
- NOP_INST, 32'h00000013, instruction driven on INSTout when no valid instruction is presented

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (reset when rst==0 at posedge clk)
- stall  in  1  downstream cannot accept this cycle
- redirect_en  in  1  branch/jump taken; restart fetch at redirect_pc
- redirect_pc  in  INS_ADDRESS  redirect target
- imem_req  out  1  read request, one cycle per request, accepted immediately
- imem_addr  out  INS_ADDRESS  request address, valid when imem_req=1
- imem_rvalid  in  1  read data valid, at least 1 cycle after the request
- imem_rdata  in  INS_W  read data
- INSTout  out  INS_W  instruction to IF/ID register
- PCout  out  INS_ADDRESS  PC of INSTout
- valid_out  out  1  INSTout/PCout hold a real instruction

Behaviour:
- Reset (rst==0):
  - pc_q=0, state=IDLE, hold buffer empty.
  - valid_out=0, INSTout=NOP_INST, PCout=0.
  - imem_req=0 while rst==0.
- Outputs INSTout, PCout and valid_out are registered. imem_req and imem_addr are combinational from state and inputs.
- Definitions:
  - accept = !valid_out | !stall.
  - Consume = valid_out & !stall at a posedge.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE:
  - imem_req=0; next state REQ.
  - IDLE is entered only from reset, so the first request issues in the 2nd cycle after reset release.
- REQ:
  - imem_req=1, imem_addr=pc_q; next state WAIT.
- WAIT, imem_rvalid=1 and accept:
  - Output register <= {imem_rdata, pc_q}; valid_out<=1; pc_q<=pc_q+PC_STEP.
  - Same cycle: imem_req=1, imem_addr=pc_q+PC_STEP; stay WAIT.
  - Sustained throughput: one instruction per rvalid.
- WAIT, imem_rvalid=1 and !accept:
  - Hold buffer <= {imem_rdata, pc_q}; pc_q<=pc_q+PC_STEP; next state HOLD.
  - No new request.
- WAIT, imem_rvalid=0: stay WAIT.
- HOLD:
  - Output register is unchanged while stall=1.
  - When stall=0: output register <= hold buffer, valid_out<=1; next state REQ.
- Drain rule: on consume with no new load this cycle, valid_out<=0 and INSTout<=NOP_INST. PCout keeps its last value.
- Redirect (redirect_en=1) has highest priority, above stall and rvalid:
  - pc_q<=redirect_pc; valid_out<=0; INSTout<=NOP_INST; hold buffer discarded.
  - imem_req forced 0 this cycle.
  - Any imem_rvalid this cycle is dropped.
  - Next state:
    - DRAIN if in WAIT with imem_rvalid=0 (request still outstanding);
    - REQ if in WAIT with imem_rvalid=1, or in HOLD or REQ;
    - IDLE stays IDLE.
- DRAIN:
  - imem_req=0.
  - On imem_rvalid, data is discarded and next state is REQ.
  - A further redirect in DRAIN updates pc_q and stays in DRAIN.
- imem_rvalid is ignored in IDLE, REQ and HOLD.
- At most one request is outstanding at any time.
- Arithmetic: pc_q+PC_STEP wraps modulo 2^INS_ADDRESS; redirect_pc is used unmodified.
- Reset mid-operation: all state is abandoned immediately. The memory must not return a response for a request issued before reset, and any such response is ignored in IDLE and REQ.

Test Plan:
- Reset release, memory latency 1, no stall:
  - imem_req first high 2 cycles after release with addr 0, then addrs 4, 8, 12 on consecutive cycles.
  - valid_out=1 with PCout=0, 4, 8 each cycle following the corresponding rvalid.
- Latency 3, no stall:
  - One request per 3 cycles.
  - Between responses, valid_out drops to 0 and INSTout=0x00000013.
- stall held 4 cycles while a response arrives:
  - Output holds its PC (e.g. 8) for all 4 cycles; the response for 12 goes to the hold buffer.
  - After stall=0, PCout=12 appears next cycle, then a request to 16.
- redirect_en with redirect_pc=0x40 while a request to 0x10 is outstanding:
  - The 0x10 response is dropped; valid_out=0.
  - Next imem_addr=0x40; the 0x10 data never appears on INSTout.
- redirect_en in the same cycle as rvalid, with stall=1:
  - Data dropped; valid_out<=0 despite stall; next request at the target.
- pc_q=0x1FC (INS_ADDRESS=9) sequential fetch:
  - Next imem_addr=0x000 (wrap).
- rst=0 asserted during WAIT:
  - Outputs reset next edge; a late rvalid is ignored; fetch restarts at 0.
